ltile_frac_logic_gen: RTL and testbench

Parametrised fractured K-input logic element for the CLB `fle` physical mode. A K-LUT splits into two (K-1)-LUTs sharing the low inputs. Configuration enters through a shadow scan chain and takes effect only on an explicit commit, so the live function never glitches while a new bitstream is shifted through. Chain-load status is exported to the tile configuration controller, and an optional parity check can reject corrupt loads.

---
 rtl/frac_logic_pkg.sv | 31 +++
 rtl/ltile_frac_cfg_chain.sv | 73 +++++++
 rtl/ltile_frac_logic_gen.sv | 57 +++++
 tb/tb_ltile_frac_logic_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/frac_logic_pkg.sv
// rtl/frac_logic_pkg.sv - shared types, config-width helper and field offsets for the fractured LUT
// Build option FRAC_LOGIC_PARITY_EN appends an even-parity bit to the configuration word.
package frac_logic_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      ARMED   = 2'd2
   } load_state_t;

`ifdef FRAC_LOGIC_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif

   localparam int TT_LSB = 0;

   function automatic int cfg_w(input int k);
      return (1 << k) + 1 + PAR_EN;
   endfunction

   function automatic int mode_bit(input int k);
      return TT_LSB + (1 << k);
   endfunction

   function automatic int par_bit(input int k);
      return mode_bit(k) + 1;
   endfunction

endpackage

// File: rtl/ltile_frac_cfg_chain.sv
// rtl/ltile_frac_cfg_chain.sv - shadow scan chain, load FSM and commit into the active config
// Build option FRAC_LOGIC_PARITY_EN gates commits on even parity over the whole chain.
module ltile_frac_cfg_chain
   import frac_logic_pkg::*;
#(
   parameter int CFG_W = 17
) (
   input  logic                      prog_clk,
   input  logic                      prog_reset_n,
   input  logic                      ccff_head,
   input  logic                      ccff_shift,
   input  logic                      ccff_commit,
   output logic                      ccff_tail,
   output logic [CFG_W-PAR_EN-1:0]   active_cfg,
   output logic                      cfg_armed,
   output logic                      cfg_valid,
   output logic                      cfg_err
);

   localparam int CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

   logic [CFG_W-1:0] sr;
   logic [CNT_W-1:0] cnt;
   load_state_t      state;
   logic             parity_ok;

`ifdef FRAC_LOGIC_PARITY_EN
   assign parity_ok = ~(^sr);
`else
   assign parity_ok = 1'b1;
`endif

   assign ccff_tail = sr[CFG_W-1];
   assign cfg_armed = (state == ARMED);

   // Commit has priority over shift so a committed word is never one bit stale.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         sr         <= '0;
         active_cfg <= '0;
         cnt        <= '0;
         state      <= EMPTY;
         cfg_valid  <= 1'b0;
         cfg_err    <= 1'b0;
      end else if (ccff_commit) begin
         if (state == ARMED && parity_ok) begin
            active_cfg <= sr[CFG_W-PAR_EN-1:0];
            cfg_valid  <= 1'b1;
            cfg_err    <= 1'b0;
            cnt        <= '0;
            state      <= EMPTY;
         end else begin
            cfg_err <= 1'b1;
         end
      end else if (ccff_shift) begin
         sr <= {sr[CFG_W-2:0], ccff_head};
         unique case (state)
            EMPTY: begin
               cnt   <= CNT_W'(1);
               state <= (CFG_W == 1) ? ARMED : PARTIAL;
            end
            PARTIAL: begin
               cnt <= cnt + 1'b1;
               if (cnt + 1'b1 == CNT_FULL)
                  state <= ARMED;
            end
            default: cnt <= CNT_FULL;
         endcase
      end
   end

endmodule

// File: rtl/ltile_frac_logic_gen.sv
// rtl/ltile_frac_logic_gen.sv - fractured K-LUT: one K-LUT or two (K-1)-LUTs sharing low inputs
// Build option FRAC_LOGIC_PARITY_EN widens the configuration chain by one parity bit.
module ltile_frac_logic_gen
   import frac_logic_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         prog_clk,
   input  logic         prog_reset_n,
   input  logic [K-1:0] frac_logic_in,
   input  logic         ccff_head,
   input  logic         ccff_shift,
   input  logic         ccff_commit,
   output logic [1:0]   frac_logic_out,
   output logic         ccff_tail,
   output logic         cfg_armed,
   output logic         cfg_valid,
   output logic         cfg_err
);

   localparam int CFG_W    = cfg_w(K);
   localparam int TT_W     = 1 << K;
   localparam int MODE_BIT = mode_bit(K);

   logic [MODE_BIT:0] active_cfg;
   logic [TT_W-1:0]   truth;
   logic              mode;
   logic              lo;
   logic              hi;
   logic              lutk;

   ltile_frac_cfg_chain #(
      .CFG_W (CFG_W)
   ) u_cfg_chain (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .ccff_head    (ccff_head),
      .ccff_shift   (ccff_shift),
      .ccff_commit  (ccff_commit),
      .ccff_tail    (ccff_tail),
      .active_cfg   (active_cfg),
      .cfg_armed    (cfg_armed),
      .cfg_valid    (cfg_valid),
      .cfg_err      (cfg_err)
   );

   assign truth = active_cfg[TT_LSB +: TT_W];
   assign mode  = active_cfg[MODE_BIT];

   // Both halves index with the shared low inputs; the top input only picks between them.
   assign lo   = truth[{1'b0, frac_logic_in[K-2:0]}];
   assign hi   = truth[{1'b1, frac_logic_in[K-2:0]}];
   assign lutk = frac_logic_in[K-1] ? hi : lo;

   assign frac_logic_out = cfg_valid ? {hi, (mode ? lo : lutk)} : 2'b00;

endmodule

// File: tb/tb_ltile_frac_logic_gen.sv
// tb/tb_ltile_frac_logic_gen.sv - directed and random checks of the fractured LUT against a bit-history model
// Honours FRAC_LOGIC_PARITY_EN when the design is built with it.
module tb_ltile_frac_logic_gen;

   localparam int K = 4;
`ifdef FRAC_LOGIC_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CFG_W = 17 + PAR;

   logic         prog_clk = 1'b0;
   logic         prog_reset_n;
   logic [K-1:0] frac_logic_in;
   logic         ccff_head;
   logic         ccff_shift;
   logic         ccff_commit;
   logic [1:0]   frac_logic_out;
   logic         ccff_tail;
   logic         cfg_armed;
   logic         cfg_valid;
   logic         cfg_err;

   int vectors     = 0;
   int miscompares = 0;

   bit        hist[$];
   int        since;
   bit        m_valid;
   bit        m_err;
   bit        m_mode;
   bit [15:0] m_truth;

   ltile_frac_logic_gen #(.K(K)) dut (
      .prog_clk       (prog_clk),
      .prog_reset_n   (prog_reset_n),
      .frac_logic_in  (frac_logic_in),
      .ccff_head      (ccff_head),
      .ccff_shift     (ccff_shift),
      .ccff_commit    (ccff_commit),
      .frac_logic_out (frac_logic_out),
      .ccff_tail      (ccff_tail),
      .cfg_armed      (cfg_armed),
      .cfg_valid      (cfg_valid),
      .cfg_err        (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   function automatic bit sr_bit(int j);
      return (j < hist.size()) ? hist[j] : 1'b0;
   endfunction

   function automatic bit par_ok();
      bit x = 1'b0;
      for (int j = 0; j < CFG_W; j++) x ^= sr_bit(j);
      return (PAR == 0) || (x == 1'b0);
   endfunction

   function automatic bit [1:0] exp_out(int a);
      bit lo, hi, o0;
      lo = m_truth[a % 8];
      hi = m_truth[8 + a % 8];
      o0 = m_mode ? lo : m_truth[a];
      return m_valid ? {hi, o0} : 2'b00;
   endfunction

   task automatic reset_model();
      hist.delete();
      since   = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_mode  = 1'b0;
      m_truth = '0;
   endtask

   task automatic model_step(bit sh, bit hd, bit cm);
      if (cm) begin
         if (since >= CFG_W && par_ok()) begin
            for (int j = 0; j < 16; j++) m_truth[j] = sr_bit(j);
            m_mode  = sr_bit(16);
            m_valid = 1'b1;
            m_err   = 1'b0;
            since   = 0;
         end else begin
            m_err = 1'b1;
         end
      end else if (sh) begin
         hist.push_front(hd);
         if (hist.size() > CFG_W) void'(hist.pop_back());
         since++;
      end
   endtask

   task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      cmp({tag, "/armed"}, 32'(cfg_armed), 32'(since >= CFG_W));
      cmp({tag, "/valid"}, 32'(cfg_valid), 32'(m_valid));
      cmp({tag, "/err"},   32'(cfg_err),   32'(m_err));
      cmp({tag, "/tail"},  32'(ccff_tail), 32'(sr_bit(CFG_W - 1)));
      cmp({tag, "/out"},   32'(frac_logic_out), 32'(exp_out(int'(frac_logic_in))));
   endtask

   task automatic sweep(string tag);
      for (int i = 0; i < 16; i++) begin
         frac_logic_in = 4'(i);
         #1;
         cmp({tag, "/sweep"}, 32'(frac_logic_out), 32'(exp_out(i)));
      end
   endtask

   task automatic cycle(bit sh, bit hd, bit cm, string tag);
      ccff_shift  = sh;
      ccff_head   = hd;
      ccff_commit = cm;
      @(posedge prog_clk);
      model_step(sh, hd, cm);
      #1;
      ccff_shift  = 1'b0;
      ccff_commit = 1'b0;
      check_all(tag);
   endtask

   task automatic load(bit [15:0] tt, bit md, bit bad, string tag);
      bit v[CFG_W];
      for (int j = 0; j < 16; j++) v[j] = tt[j];
      v[16] = md;
      for (int j = 17; j < CFG_W; j++) v[j] = ^{tt, md};
      if (bad) v[0] = ~v[0];
      for (int j = CFG_W - 1; j >= 0; j--) cycle(1'b1, v[j], 1'b0, tag);
   endtask

   initial begin
      prog_reset_n  = 1'b0;
      frac_logic_in = '0;
      ccff_head     = 1'b0;
      ccff_shift    = 1'b0;
      ccff_commit   = 1'b0;
      reset_model();
      repeat (2) @(posedge prog_clk);
      #1;
      check_all("reset");
      sweep("reset");
      prog_reset_n = 1'b1;

      // single AND-4 function
      load(16'h8000, 1'b0, 1'b0, "and4_load");
      cycle(1'b0, 1'b0, 1'b1, "and4_commit");
      sweep("and4");

      // fractured mode, two independent 3-LUTs
      load(16'h8806, 1'b1, 1'b0, "frac_load");
      cycle(1'b0, 1'b0, 1'b1, "frac_commit");
      sweep("frac");

      // premature commit after 10 shifts, then recovery
      repeat (10) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, "early_shift");
      cycle(1'b0, 1'b0, 1'b1, "early_commit");
      sweep("early");
      repeat (CFG_W - 10) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, "recov_shift");
      cycle(1'b0, 1'b0, 1'b1, "recov_commit");
      sweep("recov");

      // shift and commit together while armed, then saturate the counter
      load(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, "both_load");
      cycle(1'b1, 1'b1, 1'b1, "both_commit");
      sweep("both");
      repeat (20) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, "sat_shift");
      cycle(1'b0, 1'b0, 1'b1, "sat_commit");

      // asynchronous reset in the middle of a partial load
      repeat (5) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, "part_shift");
      frac_logic_in = 4'hF;
      prog_reset_n  = 1'b0;
      #1;
      reset_model();
      cmp("areset/out",   32'(frac_logic_out), 32'(0));
      cmp("areset/valid", 32'(cfg_valid), 32'(0));
      cmp("areset/armed", 32'(cfg_armed), 32'(0));
      @(posedge prog_clk);
      #1;
      prog_reset_n = 1'b1;
      check_all("areset_rel");

`ifdef FRAC_LOGIC_PARITY_EN
      load(16'h1234, 1'b0, 1'b1, "par_bad_load");
      cycle(1'b0, 1'b0, 1'b1, "par_bad_commit");
      sweep("par_bad");
      load(16'h1234, 1'b0, 1'b0, "par_good_load");
      cycle(1'b0, 1'b0, 1'b1, "par_good_commit");
      sweep("par_good");
`endif

      // random traffic
      for (int n = 0; n < 400; n++) begin
         frac_logic_in = 4'($urandom);
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
